// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory request FSM feeding a 2-entry {pc, instr} FIFO.
// Optional saturating decode-stall counter on o_stallCnt, enabled by defining FETCH_STALL_CNT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemData,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] o_stallCnt
`endif
);

  localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
  logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;

  logic pop, push, outstanding;
  logic [1:0] occ_pop;
  logic unused_ok;

  assign unused_ok = ^i_redirectPc[1:0];

  assign pop     = (cnt_q != 2'd0) & i_ready;
  assign push    = (state_q == WAIT) & i_imemAck & ~i_redirect;
  assign occ_pop = cnt_q - {1'b0, pop};
  // A request issued this cycle (REQ) or still unanswered must have its ack swallowed.
  assign outstanding = (state_q == REQ) |
                       (((state_q == WAIT) | (state_q == FLUSH)) & ~i_imemAck);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    pc0_d   = pc0_q;
    ins0_d  = ins0_q;
    pc1_d   = pc1_q;
    ins1_d  = ins1_q;
    if (i_redirect) begin
      cnt_d   = 2'd0;
      pc_d    = {i_redirectPc[31:2], 2'b00};
      state_d = outstanding ? FLUSH : REQ;
    end else begin
      case ({push, pop})
        2'b01: begin
          pc0_d  = pc1_q;
          ins0_d = ins1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            pc0_d  = pc_q;
            ins0_d = i_imemData;
          end else begin
            pc1_d  = pc_q;
            ins1_d = i_imemData;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            pc0_d  = pc_q;
            ins0_d = i_imemData;
          end else begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = pc_q;
            ins1_d = i_imemData;
          end
        end
        default: ;
      endcase
      case (state_q)
        IDLE:  if (occ_pop < 2'd2) state_d = REQ;
        REQ:   state_d = WAIT;
        WAIT:  if (i_imemAck) begin
                 pc_d    = pc_q + 32'd4;
                 state_d = (cnt_d < 2'd2) ? REQ : IDLE;
               end
        FLUSH: if (i_imemAck) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= PC0;
      cnt_q   <= 2'd0;
      pc0_q   <= '0;
      ins0_q  <= '0;
      pc1_q   <= '0;
      ins1_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      pc0_q   <= pc0_d;
      ins0_q  <= ins0_d;
      pc1_q   <= pc1_d;
      ins1_q  <= ins1_d;
    end
  end

  assign o_imemReq  = (state_q == REQ);
  assign o_imemAddr = pc_q;
  assign o_valid    = (cnt_q != 2'd0);
  assign o_instr    = o_valid ? ins0_q : 32'd0;
  assign o_pc       = o_valid ? pc0_q  : 32'd0;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                  stall_q <= '0;
    else if (o_valid && !i_ready && !(&stall_q)) stall_q <= stall_q + 32'd1;
  end
  assign o_stallCnt = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed phases push expected fetch addresses and
// {pc, instr} transfers; negedge monitors pop and compare whenever the DUT presents them.
module tb_instr_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ready, redirect, ack, ack2, inj;
  logic [31:0] rpc, mdata, mdata2;
  logic        req, req2, vld, vld2;
  logic [31:0] addr, addr2, ins, ins2, pc, pc2, e2;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall, stall2;
`endif
  int lat;
  int checks = 0, errors = 0;
  logic [31:0] ea[$], ep[$], ei[$], ea2[$], ep2[$];

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imemReq(req), .o_imemAddr(addr), .i_imemAck(ack), .i_imemData(mdata),
    .o_valid(vld), .o_instr(ins), .o_pc(pc), .i_ready(ready),
    .i_redirect(redirect), .i_redirectPc(rpc)
`ifdef FETCH_STALL_CNT_EN
    , .o_stallCnt(stall)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .o_imemReq(req2), .o_imemAddr(addr2), .i_imemAck(ack2), .i_imemData(mdata2),
    .o_valid(vld2), .o_instr(ins2), .o_pc(pc2), .i_ready(1'b1),
    .i_redirect(1'b0), .i_redirectPc(32'd0)
`ifdef FETCH_STALL_CNT_EN
    , .o_stallCnt(stall2)
`endif
  );

  // Memory contents: word(0) = 0x00500093 (ADDI x1,x0,5).
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic rebase(input logic [31:0] b);
    ea.delete(); ep.delete(); ei.delete();
    for (int i = 0; i < 64; i++) begin
      ea.push_back(b + 32'(4 * i));
      ep.push_back(b + 32'(4 * i));
      ei.push_back(word(b + 32'(4 * i)));
    end
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    @(negedge clk);
    while (!req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req) begin
      checks++; errors++;
      $display("FAIL %s timeout act=no_req exp=req", nm);
    end
  endtask

  // Memory models: ack 'lat' cycles after the request (dut2 fixed at 1).
  int cnt1 = 0, cnt2 = 0;
  logic [31:0] ma1, ma2;
  always @(negedge clk) begin
    ack = 1'b0;
    if (rst) cnt1 = 0;
    else if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) begin ack = 1'b1; mdata = word(ma1); end
    end
    if (inj) begin ack = 1'b1; mdata = 32'hDEAD_BEEF; end
    if (!rst && req) begin cnt1 = lat; ma1 = addr; end
  end

  always @(negedge clk) begin
    ack2 = 1'b0;
    if (rst) cnt2 = 0;
    else if (cnt2 > 0) begin
      cnt2--;
      if (cnt2 == 0) begin ack2 = 1'b1; mdata2 = word(ma2); end
    end
    if (!rst && req2) begin cnt2 = 1; ma2 = addr2; end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (req) begin
        if (ea.size() == 0) begin
          checks++; errors++;
          $display("FAIL imem_addr act=%h exp=none", addr);
        end else chk("imem_addr", addr, ea.pop_front());
      end
      if (vld && ready) begin
        if (ep.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_pc act=%h exp=none", pc);
        end else begin
          chk("out_pc", pc, ep.pop_front());
          chk("out_instr", ins, ei.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (req2 && ea2.size() > 0) chk("dut2_addr", addr2, ea2.pop_front());
      if (vld2 && ep2.size() > 0) begin
        e2 = ep2.pop_front();
        chk("dut2_pc", pc2, e2);
        chk("dut2_instr", ins2, word(e2));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hp;
    int nreq;
    rst = 1'b1; ready = 1'b1; redirect = 1'b0; rpc = '0; lat = 1; inj = 1'b0;
    ack = 1'b0; ack2 = 1'b0; mdata = '0; mdata2 = '0;
    rebase(32'h0);
    ea2.push_back(32'hFFFF_FFF8); ea2.push_back(32'hFFFF_FFFC); ea2.push_back(32'h0);
    ep2.push_back(32'hFFFF_FFF8); ep2.push_back(32'hFFFF_FFFC); ep2.push_back(32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_instr", ins, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_addr2", addr2, 32'hFFFF_FFF8);

    // Release with a bogus ack in the release cycle.
    @(posedge clk); #1 rst = 1'b0; inj = 1'b1;
    @(negedge clk); chk("rel_c1_req", 32'(req), 32'd0);
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk); chk("rel_c2_req", 32'(req), 32'd1);
    @(negedge clk); chk("c3_valid", 32'(vld), 32'd0);
    @(negedge clk); chk("c4_valid", 32'(vld), 32'd1);
    chk("c4_instr", ins, 32'h0050_0093);
    repeat (10) @(negedge clk);

    // Decode stall: FIFO fills to two, fetching halts, then drains in order.
    @(posedge clk); #1 ready = 1'b0;
    repeat (6) @(negedge clk);
    hp = pc;
    chk("stall_valid", 32'(vld), 32'd1);
    nreq = 0;
    repeat (5) begin
      @(negedge clk);
      if (req) nreq++;
    end
    chk("stall_noreq", 32'(nreq), 32'd0);
    chk("stall_head", pc, hp);
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk); chk("drain1_valid", 32'(vld), 32'd1);
    @(negedge clk); chk("drain2_valid", 32'(vld), 32'd1);
    @(negedge clk); chk("drain3_valid", 32'(vld), 32'd0);
    repeat (6) @(negedge clk);

    // Redirect while WAIT with 3-cycle memory: stale ack must be flushed.
    @(posedge clk); #1 lat = 3;
    wait_req("c_req0");
    @(posedge clk); #1 redirect = 1'b1; rpc = 32'h0000_0100;
    @(posedge clk); rebase(32'h0000_0100); #1 redirect = 1'b0;
    @(negedge clk); chk("c_valid", 32'(vld), 32'd0);
    wait_req("c_req1");
    chk("c_addr", addr, 32'h0000_0100);
    repeat (24) @(negedge clk);

    // Redirect coinciding with ack, unaligned target.
    @(posedge clk); #1 lat = 1;
    wait_req("d_req0");
    @(posedge clk); #1 redirect = 1'b1; rpc = 32'h0000_0203;
    @(posedge clk); rebase(32'h0000_0200); #1 redirect = 1'b0;
    @(negedge clk);
    chk("d_valid", 32'(vld), 32'd0);
    chk("d_req", 32'(req), 32'd1);
    chk("d_addr", addr, 32'h0000_0200);
    repeat (12) @(negedge clk);

    // Reset mid-run.
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("e_valid", 32'(vld), 32'd0);
    chk("e_req", 32'(req), 32'd0);
    chk("e_addr", addr, 32'd0);
    chk("e_pc", pc, 32'd0);
    rebase(32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (16) @(negedge clk);

`ifdef FETCH_STALL_CNT_EN
    @(posedge clk); #1 rst = 1'b1; ready = 1'b0; rebase(32'h0);
    @(posedge clk); #1 rst = 1'b0;
    nreq = 0;
    @(negedge clk);
    while (!vld && nreq < 40) begin
      @(negedge clk);
      nreq++;
    end
    repeat (6) @(negedge clk);
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk); chk("stall_cnt", stall, 32'd7);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("stall_cnt_rst", stall, 32'd0);
    chk("stall_valid_rst", 32'(vld), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
